// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding,
// captured-operation encoding and the rstatus exception codes.
package md_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } md_op_e;

  localparam logic [4:0]  RSTATUS_REG = 5'd30;
  localparam logic [31:0] EXC_MULT    = 32'd4;
  localparam logic [31:0] EXC_DIV     = 32'd5;
  localparam int unsigned CNT_W       = 6;

  function automatic logic [31:0] exc_code(input md_op_e op);
    case (op)
      OP_MULT: exc_code = EXC_MULT;
      OP_DIV:  exc_code = EXC_DIV;
      default: exc_code = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// BUSY-cycle counter for the multdiv watchdog; cleared on issue and
// advanced once per BUSY cycle.
module md_timeout_counter
  import md_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  // Counter register: clear has priority over increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= {CNT_W{1'b0}};
    end else if (clear) begin
      count <= {CNT_W{1'b0}};
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide issue sequencer: stalls the pipeline while the multdiv unit
// works and steers its result or rstatus code into the X/M latch.
// Optional watchdog enabled by defining MD_TIMEOUT_EN.
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        is_mult,
  input  logic        is_div,
  input  logic [4:0]  rd_x,
  input  logic        result_rdy,
  input  logic        exc_in,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        xm_bubble,
  output logic        md_valid,
  output logic [4:0]  rd_out,
  output logic        status_sel,
  output logic [31:0] status_val
);

  if ((MD_TIMEOUT < 2) || (MD_TIMEOUT > 63)) begin : g_bad_timeout
    $error("md_sequencer: MD_TIMEOUT must be in 2..63");
  end

  md_state_e  state_r, state_nxt_s;
  md_op_e     op_r, op_nxt_s;
  logic [4:0] rd_r, rd_nxt_s;
  logic       exc_r, exc_nxt_s;
  logic       issue_s;
  logic       timeout_s;

  // Reset gates the issue path so a held instruction cannot pulse ctrl_* under reset.
  assign issue_s = (state_r == ST_IDLE) && (is_mult || is_div) && !reset;

`ifdef MD_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MD_TIMEOUT - 1);
  logic [CNT_W-1:0] count_s;

  md_timeout_counter u_timeout_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (issue_s),
    .enable (state_r == ST_BUSY),
    .count  (count_s)
  );

  assign timeout_s = (state_r == ST_BUSY) && (count_s == TIMEOUT_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // State and captured-operation registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      op_r    <= OP_MULT;
      rd_r    <= 5'd0;
      exc_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      op_r    <= op_nxt_s;
      rd_r    <= rd_nxt_s;
      exc_r   <= exc_nxt_s;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt_s = state_r;
    op_nxt_s    = op_r;
    rd_nxt_s    = rd_r;
    exc_nxt_s   = exc_r;
    ctrl_mult   = 1'b0;
    ctrl_div    = 1'b0;
    stall       = 1'b0;
    xm_bubble   = 1'b0;
    md_valid    = 1'b0;
    rd_out      = 5'd0;
    status_sel  = 1'b0;
    status_val  = 32'd0;
    case (state_r)
      ST_IDLE: begin
        if (issue_s) begin
          ctrl_mult   = is_mult;
          ctrl_div    = ~is_mult;
          stall       = 1'b1;
          xm_bubble   = 1'b1;
          op_nxt_s    = is_mult ? OP_MULT : OP_DIV;
          rd_nxt_s    = rd_x;
          exc_nxt_s   = 1'b0;
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        stall     = 1'b1;
        xm_bubble = 1'b1;
        if (result_rdy) begin
          exc_nxt_s   = exc_in;
          state_nxt_s = ST_DONE;
        end else if (timeout_s) begin
          exc_nxt_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        md_valid = 1'b1;
        if (exc_r) begin
          rd_out     = RSTATUS_REG;
          status_sel = 1'b1;
          status_val = exc_code(op_r);
        end else begin
          rd_out     = rd_r;
        end
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed vector table, multi-cycle
// corner sequences and randomized transactions against a per-transaction model.
module tb_md_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        is_mult = 1'b0;
  logic        is_div = 1'b0;
  logic [4:0]  rd_x = 5'd0;
  logic        result_rdy = 1'b0;
  logic        exc_in = 1'b0;
  logic        ctrl_mult, ctrl_div, stall, xm_bubble, md_valid, status_sel;
  logic [4:0]  rd_out;
  logic [31:0] status_val;

  md_sequencer #(.MD_TIMEOUT(40)) dut (
    .clock      (clock),
    .reset      (reset),
    .is_mult    (is_mult),
    .is_div     (is_div),
    .rd_x       (rd_x),
    .result_rdy (result_rdy),
    .exc_in     (exc_in),
    .ctrl_mult  (ctrl_mult),
    .ctrl_div   (ctrl_div),
    .stall      (stall),
    .xm_bubble  (xm_bubble),
    .md_valid   (md_valid),
    .rd_out     (rd_out),
    .status_sel (status_sel),
    .status_val (status_val)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       is_mult;
    logic       is_div;
    logic [4:0] rd_x;
    logic       result_rdy;
    logic       exc_in;
  } in_t;

  typedef struct packed {
    logic        ctrl_mult;
    logic        ctrl_div;
    logic        stall;
    logic        xm_bubble;
    logic        md_valid;
    logic [4:0]  rd_out;
    logic        status_sel;
    logic [31:0] status_val;
  } out_t;

  typedef struct {
    in_t   in;
    out_t  exp;
    string name;
  } vec_t;

  out_t act;
  assign act = {ctrl_mult, ctrl_div, stall, xm_bubble, md_valid, rd_out, status_sel, status_val};

  int vectors = 0;
  int miscompares = 0;
  int stall_seen = 0;

  function automatic in_t mk_in(input logic m, input logic d, input logic [4:0] rd,
                                input logic rr, input logic e);
    in_t i;
    i.is_mult = m; i.is_div = d; i.rd_x = rd; i.result_rdy = rr; i.exc_in = e;
    return i;
  endfunction

  function automatic out_t o_zero();
    out_t o = '0;
    return o;
  endfunction

  function automatic out_t o_issue(input logic m, input logic d);
    out_t o = '0;
    o.ctrl_mult = m;
    o.ctrl_div  = d & ~m;
    o.stall     = 1'b1;
    o.xm_bubble = 1'b1;
    return o;
  endfunction

  function automatic out_t o_busy();
    out_t o = '0;
    o.stall     = 1'b1;
    o.xm_bubble = 1'b1;
    return o;
  endfunction

  function automatic out_t o_done(input logic [4:0] rd, input logic e, input logic was_mult);
    out_t o = '0;
    o.md_valid   = 1'b1;
    o.rd_out     = e ? 5'd30 : rd;
    o.status_sel = e;
    o.status_val = e ? (was_mult ? 32'd4 : 32'd5) : 32'd0;
    return o;
  endfunction

  task automatic drive(input in_t in);
    is_mult    = in.is_mult;
    is_div     = in.is_div;
    rd_x       = in.rd_x;
    result_rdy = in.result_rdy;
    exc_in     = in.exc_in;
  endtask

  task automatic check(input out_t exp, input string name);
    vectors++;
    if (act.stall) stall_seen++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input in_t in, input out_t exp, input string name);
    drive(in);
    #2;
    check(exp, name);
    @(posedge clock);
    #1;
  endtask

  // One full md transaction: issue, lat BUSY cycles ending in result_rdy, DONE.
  task automatic run_txn(input logic m, input logic d, input logic [4:0] rd,
                         input int lat, input logic e, input logic hold_done);
    apply(mk_in(m, d, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))),
          o_issue(m, d), "txn_issue");
    for (int i = 1; i <= lat; i++) begin
      apply(mk_in(m, d, rd, (i == lat) ? 1'b1 : 1'b0,
                  (i == lat) ? e : 1'($urandom_range(0, 1))),
            o_busy(), "txn_busy");
    end
    apply(mk_in(hold_done ? m : 1'b0, hold_done ? d : 1'b0, rd,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))),
          o_done(rd, e, m), "txn_done");
  endtask

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{mk_in(1'b0, 1'b0, 5'd0,  1'b0, 1'b0), o_zero(),                   "idle_zero"};
    tbl[1]  = '{mk_in(1'b0, 1'b0, 5'd17, 1'b1, 1'b1), o_zero(),                   "idle_rdy_ignored"};
    tbl[2]  = '{mk_in(1'b0, 1'b1, 5'd9,  1'b1, 1'b0), o_issue(1'b0, 1'b1),        "div_issue"};
    tbl[3]  = '{mk_in(1'b0, 1'b1, 5'd9,  1'b0, 1'b0), o_busy(),                   "div_busy"};
    tbl[4]  = '{mk_in(1'b0, 1'b1, 5'd9,  1'b1, 1'b1), o_busy(),                   "div_rdy_exc"};
    tbl[5]  = '{mk_in(1'b0, 1'b1, 5'd9,  1'b0, 1'b0), o_done(5'd9, 1'b1, 1'b0),   "div_done_exc"};
    tbl[6]  = '{mk_in(1'b0, 1'b0, 5'd0,  1'b0, 1'b0), o_zero(),                   "after_done_idle"};
    tbl[7]  = '{mk_in(1'b1, 1'b1, 5'd3,  1'b0, 1'b0), o_issue(1'b1, 1'b1),        "both_mult_wins"};
    tbl[8]  = '{mk_in(1'b1, 1'b1, 5'd3,  1'b1, 1'b1), o_busy(),                   "both_rdy_ovf"};
    tbl[9]  = '{mk_in(1'b1, 1'b1, 5'd3,  1'b0, 1'b0), o_done(5'd3, 1'b1, 1'b1),   "both_done_exc4"};
    tbl[10] = '{mk_in(1'b1, 1'b0, 5'd12, 1'b0, 1'b0), o_issue(1'b1, 1'b0),        "b2b_issue"};
    tbl[11] = '{mk_in(1'b1, 1'b0, 5'd12, 1'b1, 1'b0), o_busy(),                   "b2b_rdy"};
    tbl[12] = '{mk_in(1'b1, 1'b0, 5'd12, 1'b0, 1'b0), o_done(5'd12, 1'b0, 1'b1),  "b2b_done_ok"};
    tbl[13] = '{mk_in(1'b0, 1'b0, 5'd0,  1'b0, 1'b0), o_zero(),                   "final_idle"};

    // Reset with an instruction present must hold every output low.
    drive(mk_in(1'b1, 1'b0, 5'd5, 1'b1, 1'b0));
    #2;
    check(o_zero(), "reset_outputs");
    @(posedge clock);
    #1;
    drive(mk_in(1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
    reset = 1'b0;

    for (int v = 0; v < 14; v++) begin
      apply(tbl[v].in, tbl[v].exp, tbl[v].name);
    end

    // Mult with result 32 cycles after issue: 33 stall cycles then clean writeback.
    stall_seen = 0;
    apply(mk_in(1'b1, 1'b0, 5'd7, 1'b0, 1'b0), o_issue(1'b1, 1'b0), "long_issue");
    for (int i = 1; i <= 32; i++) begin
      apply(mk_in(1'b1, 1'b0, 5'd7, (i == 32) ? 1'b1 : 1'b0, 1'b0), o_busy(), "long_busy");
    end
    apply(mk_in(1'b1, 1'b0, 5'd7, 1'b0, 1'b0), o_done(5'd7, 1'b0, 1'b1), "long_done");
    vectors++;
    if (stall_seen != 33) begin
      miscompares++;
      $display("FAIL long_stall_count: got %0d expected %0d", stall_seen, 33);
    end

    // Two consecutive muls: second issue right after the first DONE.
    run_txn(1'b1, 1'b0, 5'd4, 3, 1'b0, 1'b1);
    run_txn(1'b1, 1'b0, 5'd6, 2, 1'b0, 1'b0);
    apply(mk_in(1'b0, 1'b0, 5'd0, 1'b0, 1'b0), o_zero(), "b2b_tail_idle");

    // Reset in BUSY cycle 10, then a stale result_rdy.
    apply(mk_in(1'b1, 1'b0, 5'd11, 1'b0, 1'b0), o_issue(1'b1, 1'b0), "rst_issue");
    for (int i = 1; i <= 9; i++) begin
      apply(mk_in(1'b1, 1'b0, 5'd11, 1'b0, 1'b0), o_busy(), "rst_busy");
    end
    drive(mk_in(1'b1, 1'b0, 5'd11, 1'b0, 1'b0));
    #1;
    reset = 1'b1;
    #1;
    check(o_zero(), "reset_mid_busy");
    @(posedge clock);
    #1;
    check(o_zero(), "reset_held");
    reset = 1'b0;
    apply(mk_in(1'b0, 1'b0, 5'd11, 1'b1, 1'b0), o_zero(), "stale_rdy_ignored");
    apply(mk_in(1'b0, 1'b0, 5'd0,  1'b0, 1'b0), o_zero(), "no_md_valid");
    run_txn(1'b0, 1'b1, 5'd2, 1, 1'b0, 1'b0);
    apply(mk_in(1'b0, 1'b0, 5'd0, 1'b0, 1'b0), o_zero(), "post_rst_idle");

`ifdef MD_TIMEOUT_EN
    // Watchdog: 40 BUSY cycles without result_rdy force an exception.
    for (int k = 0; k < 2; k++) begin
      apply(mk_in(k == 0, k == 1, 5'd5, 1'b0, 1'b0), o_issue(k == 0, k == 1), "to_issue");
      for (int i = 1; i <= 40; i++) begin
        apply(mk_in(k == 0, k == 1, 5'd5, 1'b0, 1'b0), o_busy(), "to_busy");
      end
      apply(mk_in(1'b0, 1'b0, 5'd0, 1'b0, 1'b0), o_done(5'd5, 1'b1, k == 0), "to_done");
    end
`endif

    // Randomized transactions with idle gaps and spurious result_rdy noise.
    for (int t = 0; t < 60; t++) begin
      logic       m, d, e, hold;
      logic [4:0] rd;
      int         gap, lat;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        apply(mk_in(1'b0, 1'b0, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1))), o_zero(), "rand_gap");
      end
      m    = 1'($urandom_range(0, 1));
      d    = m ? 1'($urandom_range(0, 1)) : 1'b1;
      rd   = 5'($urandom_range(0, 31));
      lat  = $urandom_range(1, 12);
      e    = 1'($urandom_range(0, 1));
      hold = 1'($urandom_range(0, 1));
      run_txn(m, d, rd, lat, e, hold);
    end
    apply(mk_in(1'b0, 1'b0, 5'd0, 1'b0, 1'b0), o_zero(), "rand_end_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 Parameter MD_TIMEOUT, default 40, meaning BUSY cycles allowed before a forced exception (range 2..63).
REQ-002 clock  input  1  rising-edge clock shared with all pipeline latches.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 is_mult  input  1  decoded mul instruction present in X stage (from D/X latch).
REQ-005 is_div  input  1  decoded div instruction present in X stage.
REQ-006 rd_x  input  5  destination register of the X-stage instruction.
REQ-007 result_rdy  input  1  multdiv unit result-valid pulse.
REQ-008 exc_in  input  1  multdiv unit exception (overflow / divide-by-zero), valid with result_rdy.
REQ-009 ctrl_mult  output  1  one-cycle start pulse to multdiv for multiply.
REQ-010 ctrl_div  output  1  one-cycle start pulse to multdiv for divide.
REQ-011 stall  output  1  freezes PC, F/D and D/X latch enables.
REQ-012 xm_bubble  output  1  forces a nop (IR=0, rd=0) into the X/M latch.
REQ-013 md_valid  output  1  X/M latch selects the multdiv result / status value this cycle.
REQ-014 rd_out  output  5  destination for X/M latch when md_valid.
REQ-015 status_sel  output  1  X/M O input takes status_val instead of the multdiv result.
REQ-016 status_val  output  32  rstatus code: 4 for mult, 5 for div, else 0.

Function
REQ-017 States IDLE, BUSY, DONE; state, captured op, captured rd and counter are registered.
REQ-018 IDLE with is_mult or is_div: ctrl_mult/ctrl_div=1 combinationally that cycle, stall=1, xm_bubble=1, capture op and rd_x, next BUSY.
REQ-019 is_mult and is_div both high: mult wins; only ctrl_mult pulses.
REQ-020 BUSY: stall=1, xm_bubble=1, ctrl_* =0; result_rdy=1 -> next DONE, latch exc_in.
REQ-021 DONE: stall=0, xm_bubble=0, md_valid=1 for exactly one cycle, next IDLE unconditionally; is_mult/is_div still high in DONE shall not re-issue.
REQ-022 DONE without exception: rd_out=captured rd, status_sel=0, status_val=0.
REQ-023 DONE with exception: rd_out=30, status_sel=1, status_val=4 (mult) or 5 (div).
REQ-024 result_rdy in IDLE or in the issue cycle is ignored.
REQ-025 Back-to-back md instructions: the cycle after DONE, IDLE issues the next one with no extra bubble.
REQ-026 All outputs zero in IDLE with no md instruction present.

Reset
REQ-027 reset asserted forces IDLE, counter=0, captured op/rd/exception=0, and all outputs 0 immediately, including mid-BUSY.
REQ-028 After reset release, a result_rdy left over from an aborted operation is ignored (state is IDLE).

Configuration
REQ-029 Macro MD_TIMEOUT_EN defined: 6-bit counter clears on issue, increments each BUSY cycle; reaching MD_TIMEOUT without result_rdy -> DONE with exception forced.
REQ-030 MD_TIMEOUT_EN undefined: no counter logic; BUSY waits indefinitely for result_rdy.

Structure
REQ-031 Shared package md_pkg holds state encoding, RSTATUS_REG=30, EXC_MULT=4, EXC_DIV=5.
REQ-032 Counter lives in sub-module md_timeout_counter, instantiated only under MD_TIMEOUT_EN.

Verification
REQ-033 is_mult=1, rd_x=7, result_rdy 32 cycles later, exc_in=0 -> ctrl_mult 1 cycle, stall 33 cycles, then md_valid=1, rd_out=7, status_sel=0.
REQ-034 is_div=1, rd_x=9, result_rdy with exc_in=1 -> DONE: rd_out=30, status_sel=1, status_val=5.
REQ-035 is_mult and is_div both 1 -> only ctrl_mult pulses; overflow exception yields status_val=4.
REQ-036 Two consecutive mul instructions -> second ctrl_mult exactly one cycle after first DONE, single md_valid each.
REQ-037 reset pulsed in BUSY cycle 10, then result_rdy -> all outputs 0, state IDLE, no md_valid.
REQ-038 MD_TIMEOUT_EN, MD_TIMEOUT=40, result_rdy never -> DONE after 40 BUSY cycles with rd_out=30, status_val per op.
